// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge collector with round-robin event serialiser
// Rise/fall edges latch pending entries (2*ch rise, 2*ch+1 fall) offered one at a time on a valid/ready port.
module edge_event_arbiter #(
   parameter int N_CH = 4,
   parameter int ID_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] level,
   input  logic [N_CH-1:0] rise_en,
   input  logic [N_CH-1:0] fall_en,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [ID_W-1:0] evt_ch,
   output logic            evt_edge,
   output logic [N_CH-1:0] ovf,
   input  logic            ovf_clr
);

   localparam int N_E = 2 * N_CH;
   localparam int PW  = $clog2(N_E);

   typedef enum logic {S_IDLE, S_OFFER} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_primed;
   logic [N_CH-1:0] r_hist;
   logic [N_E-1:0]  r_pend;
   logic [PW-1:0]   r_ptr, r_sel;
   logic            r_valid;
   logic [ID_W-1:0] r_ch;
   logic            r_evt_edge;
   logic [N_CH-1:0] r_ovf;

   logic [N_E-1:0]  w_det, w_take, w_pend_nxt;
   logic [N_CH-1:0] w_ovf_set, w_ovf_nxt;
   logic [PW:0]     w_idx;
   logic            w_found;
   logic [PW-1:0]   w_win, w_ptr_nxt, w_sel_nxt;
   logic            w_valid_nxt, w_evt_edge_nxt;
   logic [ID_W-1:0] w_ch_nxt;

   assign evt_valid = r_valid;
   assign evt_ch    = r_ch;
   assign evt_edge  = r_evt_edge;
   assign ovf       = r_ovf;

   // Edges are suppressed until the history has been loaded once after reset.
   always_comb begin
      w_det = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_det[2*i]   = r_primed & level[i] & ~r_hist[i] & rise_en[i];
         w_det[2*i+1] = r_primed & ~level[i] & r_hist[i] & fall_en[i];
      end
   end

   always_comb begin
      w_take = '0;
      if (r_state == S_OFFER && evt_ready) begin
         w_take[r_sel] = 1'b1;
      end
   end

   // An edge on an entry that is being consumed this cycle re-arms it instead of overflowing.
   always_comb begin
      w_ovf_set = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_ovf_set[i] = (w_det[2*i]   & r_pend[2*i]   & ~w_take[2*i]) |
                        (w_det[2*i+1] & r_pend[2*i+1] & ~w_take[2*i+1]);
      end
      w_pend_nxt = (r_pend & ~w_take) | w_det;
      w_ovf_nxt  = (ovf_clr ? '0 : r_ovf) | w_ovf_set;
   end

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int j = 0; j < N_E; j++) begin
         w_idx = {1'b0, r_ptr} + (PW+1)'(j);
         if (w_idx >= (PW+1)'(N_E)) begin
            w_idx = w_idx - (PW+1)'(N_E);
         end
         if (!w_found && r_pend[w_idx[PW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_valid_nxt    = r_valid;
      w_ch_nxt       = r_ch;
      w_evt_edge_nxt = r_evt_edge;
      w_sel_nxt      = r_sel;
      w_ptr_nxt      = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_valid_nxt    = 1'b1;
               w_ch_nxt       = ID_W'(w_win >> 1);
               w_evt_edge_nxt = ~w_win[0];
               w_sel_nxt      = w_win;
               w_state_nxt    = S_OFFER;
            end
         end
         S_OFFER: begin
            if (evt_ready) begin
               w_valid_nxt = 1'b0;
               w_ptr_nxt   = (r_sel == PW'(N_E - 1)) ? '0 : r_sel + 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_primed   <= 1'b0;
         r_hist     <= '0;
         r_pend     <= '0;
         r_ptr      <= '0;
         r_sel      <= '0;
         r_valid    <= 1'b0;
         r_ch       <= '0;
         r_evt_edge <= 1'b0;
         r_ovf      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_primed   <= 1'b1;
         r_hist     <= level;
         r_pend     <= w_pend_nxt;
         r_ptr      <= w_ptr_nxt;
         r_sel      <= w_sel_nxt;
         r_valid    <= w_valid_nxt;
         r_ch       <= w_ch_nxt;
         r_evt_edge <= w_evt_edge_nxt;
         r_ovf      <= w_ovf_nxt;
      end
   end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event collector and scheduler for the team's level/edge-detector front end.
- Watches N_CH already-synchronised level inputs and detects rising and falling edges per channel, each gated by an enable mask.
- Latches each edge as a pending event and serialises pending events onto one valid/ready event port using round-robin arbitration.
- Flags per-channel overflow when an event is lost.

Parameters:
N_CH, 4, number of level channels (2..16)
ID_W, 2, width of channel index; must satisfy 2**ID_W >= N_CH

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
level  input  N_CH  per-channel level, synchronous to clk
rise_en  input  N_CH  per-channel rising-edge enable
fall_en  input  N_CH  per-channel falling-edge enable
evt_valid  output  1  event offered
evt_ready  input  1  consumer accepts event
evt_ch  output  ID_W  channel of offered event
evt_edge  output  1  1 = rising, 0 = falling
ovf  output  N_CH  sticky per-channel overflow flags
ovf_clr  input  1  one-cycle pulse; clears all ovf bits

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - evt_valid=0, evt_ch=0, evt_edge=0, ovf=0.
  - All pending bits=0, level history=0, primed=0, RR pointer=0, FSM=IDLE.
- Priming:
  - The first clock after reset release loads the level history and sets primed.
  - No edges are detected in that cycle, so a level that is high out of reset does not create a rise event.
- Edge detect (combinational, only when primed=1):
  - rise[i] = level[i] & ~hist[i] & rise_en[i]
  - fall[i] = ~level[i] & hist[i] & fall_en[i]
  - hist <= level every clock.
- Pending entries:
  - 2*N_CH one-bit entries; entry 2i = rise of channel i, entry 2i+1 = fall of channel i.
  - A detected edge sets its entry at the next clock edge.
  - Clearing an enable bit never clears an existing pending entry.
- Overflow:
  - An edge arriving while its entry is already pending and not being consumed that cycle sets ovf[i] and is dropped.
  - If the entry is being consumed in the same cycle, the new edge re-sets the entry and ovf is not set.
  - ovf_clr clears all ovf bits. If a set and a clear hit the same bit in the same cycle, set wins.
- FSM, two states:
  - IDLE: if any entry is pending, pick one round-robin and register evt_ch=k>>1, evt_edge=~k[0], evt_valid=1; go to OFFER. Otherwise stay in IDLE with evt_valid=0.
  - OFFER: evt_valid, evt_ch and evt_edge are held stable until evt_ready=1. On the handshake clock, clear entry k, set pointer=(k+1) mod 2*N_CH, drop evt_valid, and return to IDLE.
- Round-robin:
  - Search entries starting at pointer, ascending, wrapping at 2*N_CH.
  - The first pending entry wins.
- Latency and throughput:
  - Edge visible on level at clock t → entry set at t+1 → evt_valid high at t+2.
  - Maximum throughput is one event per 2 cycles (IDLE bubble after each handshake).
- evt_ready while evt_valid=0 is ignored.
- Reset asserted mid-offer: all state returns to reset values immediately (asynchronous); the offered event is discarded.

Test Plan:
1. Reset release with level=4'b0001 and all enables=1 → no event ever; level low on ch0 at t → evt_valid=1, evt_ch=0, evt_edge=0 at t+2.
2. Rise on ch2 with evt_ready held 0 for 5 cycles → evt_valid, evt_ch=2 and evt_edge=1 stay stable for all 5 cycles. Raise ready → one handshake, evt_valid=0 the next cycle.
3. Same-cycle rises on ch0, ch1, ch3 with ready=1 → events emitted in order ch0, ch1, ch3, each 2 cycles apart. A further rise on ch0 after that is served after any pending ch1 entry (pointer past entry 0).
4. rise_en[1]=0, fall_en[1]=1; toggle ch1 high then low → only a fall event (evt_ch=1, evt_edge=0) is produced.
5. With ready=0, pulse ch3 rise twice (rise, fall disabled, rise) → ovf=4'b1000 and only one ch3 rise is delivered. ovf_clr pulse → ovf=0. A new overflow in the same cycle as ovf_clr → ovf[3] stays 1.
6. Assert reset while evt_valid=1 → evt_valid=0 and ovf=0 the same cycle. After release with unchanged levels, no event is produced.
